// File: rtl/gpio_axis_mux_writer_pkg.sv
// Shared GPIO field layout and helpers for the PS GPIO bridges.
// Includes beat sizing and the control address used by the Ising core.
package gpio_axis_mux_writer_pkg;

   localparam int GPIO_W          = 32;
   localparam int gpio_data_width = 8;
   localparam int gpio_addr_width = 8;
   localparam int W_CLK_BIT       = 31;
   localparam int ADDR_LSB        = 8;
   localparam int DATA_LSB        = 0;
   localparam int num_bits        = 16;

   typedef logic [gpio_addr_width-1:0] chan_addr_t;
   typedef logic [gpio_data_width-1:0] gpio_byte_t;

   function automatic int beats_per_word(input int w);
      return (w + gpio_data_width - 1) / gpio_data_width;
   endfunction

   function automatic int gpio_ctrl_addr(input int base, input int n);
      return base + n;
   endfunction

endpackage

// File: rtl/gpio_axis_mux_writer_strobe_sync.sv
// w_clk synchroniser with a registered rising-edge pulse.
// Reusable by any PS GPIO bridge that needs one event per strobe.
module gpio_strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= '0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], strobe};
         prev  <= sync[SYNC_STAGES-1];
         pulse <= sync[SYNC_STAGES-1] & ~prev;
      end
   end

endmodule

// File: rtl/gpio_axis_mux_writer.sv
// PS GPIO byte writes to NUM_CH AXI-Stream channels, MSB-first
// word assembly, sticky overflow and per-channel clear.
module gpio_axis_mux_writer
   import gpio_axis_mux_writer_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int BASE_ADDR   = 0,
   parameter int CTRL_ADDR   = gpio_ctrl_addr(BASE_ADDR, NUM_CH),
   parameter int DATA_W      = num_bits,
   parameter int BEATS       = beats_per_word(DATA_W),
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [GPIO_W-1:0]        gpio_in,
   output logic [NUM_CH*DATA_W-1:0] m_data,
   output logic [NUM_CH-1:0]        m_valid,
   input  logic [NUM_CH-1:0]        m_rdy,
   output logic [NUM_CH-1:0]        ovf,
   output logic [NUM_CH-1:0]        beat_pend
);

   localparam int ACC_W = BEATS * gpio_data_width;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic       ev;
   logic       ctrl_hit;
   chan_addr_t addr;
   gpio_byte_t data;
   logic       unused_bits;

   assign addr        = gpio_in[ADDR_LSB +: gpio_addr_width];
   assign data        = gpio_in[DATA_LSB +: gpio_data_width];
   assign unused_bits = ^gpio_in[W_CLK_BIT-1:ADDR_LSB+gpio_addr_width];
   assign ctrl_hit    = ev && (addr == chan_addr_t'(CTRL_ADDR));

   gpio_strobe_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .strobe(gpio_in[W_CLK_BIT]),
      .pulse (ev)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic              hit;
      logic              clr;
      logic              last;
      logic              can_load;
      logic [CNT_W-1:0]  cnt;
      logic [ACC_W-1:0]  acc;
      logic [ACC_W-1:0]  acc_nxt;
      logic [DATA_W-1:0] word;
      logic              vld;
      logic              ovf_q;

      if (i < gpio_data_width) begin : g_clr
         assign clr = ctrl_hit & data[i];
      end else begin : g_noclr
         assign clr = 1'b0;
      end

      assign hit      = ev && (addr == chan_addr_t'(BASE_ADDR + i));
      assign last     = (cnt == CNT_W'(BEATS - 1));
      assign acc_nxt  = ACC_W'({acc, data});
      // A consume in the same cycle frees the slot for the new word.
      assign can_load = !vld || m_rdy[i];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt   <= '0;
            acc   <= '0;
            word  <= '0;
            vld   <= 1'b0;
            ovf_q <= 1'b0;
         end else begin
            if (vld && m_rdy[i])
               vld <= 1'b0;
            if (clr) begin
               cnt   <= '0;
               acc   <= '0;
               ovf_q <= 1'b0;
            end else if (hit) begin
               acc <= acc_nxt;
               if (last) begin
                  cnt <= '0;
                  if (can_load) begin
                     word <= acc_nxt[DATA_W-1:0];
                     vld  <= 1'b1;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end

      assign m_data[i*DATA_W +: DATA_W] = word;
      assign m_valid[i]                 = vld;
      assign ovf[i]                     = ovf_q;
      assign beat_pend[i]               = (cnt != '0);
   end

endmodule

// File: tb/tb_gpio_axis_mux_writer.sv
// Self-checking bench for gpio_axis_mux_writer (4 ch, 16-bit, 2 beats).
// Vector table, directed corner sequences and a random phase vs a byte-queue model.
module tb_gpio_axis_mux_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] gpio_in = '0;
   logic [63:0] m_data;
   logic [3:0]  m_valid;
   logic [3:0]  m_rdy = '0;
   logic [3:0]  ovf;
   logic [3:0]  beat_pend;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gpio_axis_mux_writer #(
      .NUM_CH     (4),
      .BASE_ADDR  (0),
      .DATA_W     (16),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .gpio_in  (gpio_in),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_rdy    (m_rdy),
      .ovf      (ovf),
      .beat_pend(beat_pend)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [3:0]  rdy;
      logic [3:0]  vld;
      logic [3:0]  ovf;
      logic [3:0]  pend;
      logic [63:0] mdata;
   } vec_t;

   vec_t tbl[17];

   // reference model: bytes received so far per channel, plus output slot
   logic [7:0]  mq[4][$];
   logic [15:0] mw[4];
   logic        mv[4];
   logic        mo[4];

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic gpio_write(input logic [7:0] a, input logic [7:0] d,
                             input int hi);
      @(negedge clk);
      gpio_in = {1'b1, 15'd0, a, d};
      repeat (hi) @(negedge clk);
      gpio_in[31] = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         mw[i] = '0;
         mv[i] = 1'b0;
         mo[i] = 1'b0;
      end
   endtask

   task automatic model_write(input logic [7:0] a, input logic [7:0] d,
                              input logic [3:0] r);
      logic [15:0] wd;
      for (int i = 0; i < 4; i++)
         if (r[i]) mv[i] = 1'b0;
      if (a < 8'd4) begin
         mq[a].push_back(d);
         if (mq[a].size() == 2) begin
            wd = {mq[a][0], mq[a][1]};
            mq[a].delete();
            if (!mv[a]) begin
               mw[a] = wd;
               mv[a] = 1'b1;
            end else begin
               mo[a] = 1'b1;
            end
         end
      end else if (a == 8'd4) begin
         for (int i = 0; i < 4; i++)
            if (d[i]) begin
               mq[i].delete();
               mo[i] = 1'b0;
            end
      end
      for (int i = 0; i < 4; i++)
         if (r[i]) mv[i] = 1'b0;
   endtask

   task automatic model_cmp(input int it);
      logic [63:0] ed;
      logic [3:0]  ev, eo, ep;
      for (int i = 0; i < 4; i++) begin
         ed[i*16 +: 16] = mw[i];
         ev[i] = mv[i];
         eo[i] = mo[i];
         ep[i] = (mq[i].size() != 0);
      end
      chk($sformatf("rnd%0d_data", it), m_data, ed);
      chk($sformatf("rnd%0d_valid", it), {60'd0, m_valid}, {60'd0, ev});
      chk($sformatf("rnd%0d_ovf", it), {60'd0, ovf}, {60'd0, eo});
      chk($sformatf("rnd%0d_pend", it), {60'd0, beat_pend}, {60'd0, ep});
   endtask

   initial begin
      int          first;
      logic [7:0]  a, d;
      logic [3:0]  r;
      int          sel;

      tbl[0]  = '{8'h00, 8'h12, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 64'h0};
      tbl[1]  = '{8'h00, 8'h34, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 64'h1234};
      tbl[2]  = '{8'h01, 8'hAA, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 64'h1234};
      tbl[3]  = '{8'h01, 8'hAA, 4'b0001, 4'b0010, 4'b0000, 4'b0000,
                  64'h0000_0000_AAAA_1234};
      tbl[4]  = '{8'h01, 8'hBB, 4'b0001, 4'b0010, 4'b0000, 4'b0010,
                  64'h0000_0000_AAAA_1234};
      tbl[5]  = '{8'h01, 8'hBB, 4'b0001, 4'b0010, 4'b0010, 4'b0000,
                  64'h0000_0000_AAAA_1234};
      tbl[6]  = '{8'h20, 8'h00, 4'b0011, 4'b0000, 4'b0010, 4'b0000,
                  64'h0000_0000_AAAA_1234};
      tbl[7]  = '{8'h03, 8'h99, 4'b0011, 4'b0000, 4'b0010, 4'b1000,
                  64'h0000_0000_AAAA_1234};
      tbl[8]  = '{8'h04, 8'h08, 4'b0011, 4'b0000, 4'b0010, 4'b0000,
                  64'h0000_0000_AAAA_1234};
      tbl[9]  = '{8'h03, 8'hAB, 4'b0011, 4'b0000, 4'b0010, 4'b1000,
                  64'h0000_0000_AAAA_1234};
      tbl[10] = '{8'h03, 8'hCD, 4'b0011, 4'b1000, 4'b0010, 4'b0000,
                  64'hABCD_0000_AAAA_1234};
      tbl[11] = '{8'h03, 8'h11, 4'b0011, 4'b1000, 4'b0010, 4'b1000,
                  64'hABCD_0000_AAAA_1234};
      tbl[12] = '{8'h03, 8'h22, 4'b0011, 4'b1000, 4'b1010, 4'b0000,
                  64'hABCD_0000_AAAA_1234};
      tbl[13] = '{8'h03, 8'h33, 4'b0011, 4'b1000, 4'b1010, 4'b1000,
                  64'hABCD_0000_AAAA_1234};
      tbl[14] = '{8'h04, 8'h08, 4'b0011, 4'b1000, 4'b0010, 4'b0000,
                  64'hABCD_0000_AAAA_1234};
      tbl[15] = '{8'h04, 8'hF2, 4'b0011, 4'b1000, 4'b0000, 4'b0000,
                  64'hABCD_0000_AAAA_1234};
      tbl[16] = '{8'hFF, 8'h11, 4'b0011, 4'b1000, 4'b0000, 4'b0000,
                  64'hABCD_0000_AAAA_1234};

      repeat (3) @(negedge clk);
      chk("rst_data", m_data, 64'h0);
      chk("rst_valid", {60'd0, m_valid}, 64'h0);
      chk("rst_ovf", {60'd0, ovf}, 64'h0);
      chk("rst_pend", {60'd0, beat_pend}, 64'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int k = 0; k < 17; k++) begin
         m_rdy = tbl[k].rdy;
         gpio_write(tbl[k].addr, tbl[k].data, 4);
         chk($sformatf("tbl%0d_data", k), m_data, tbl[k].mdata);
         chk($sformatf("tbl%0d_valid", k), {60'd0, m_valid},
             {60'd0, tbl[k].vld});
         chk($sformatf("tbl%0d_ovf", k), {60'd0, ovf}, {60'd0, tbl[k].ovf});
         chk($sformatf("tbl%0d_pend", k), {60'd0, beat_pend},
             {60'd0, tbl[k].pend});
      end

      // latency and single-cycle valid on ch0
      gpio_write(8'h00, 8'h12, 4);
      @(negedge clk);
      gpio_in = {1'b1, 15'd0, 8'h00, 8'h34};
      first = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         if (m_valid[0] && first == 0) first = k;
      end
      chk("lat_edges", 64'(first), 64'd4);
      chk("lat_data", {48'd0, m_data[15:0]}, 64'h1234);
      @(posedge clk);
      #1;
      chk("lat_one_cycle", {63'd0, m_valid[0]}, 64'd0);
      @(negedge clk);
      gpio_in[31] = 1'b0;
      repeat (6) @(negedge clk);

      // long w_clk pulse yields one beat
      m_rdy = 4'b0001;
      gpio_write(8'h01, 8'h5A, 20);
      chk("long_pend", {63'd0, beat_pend[1]}, 64'd1);
      chk("long_valid", {63'd0, m_valid[1]}, 64'd0);
      gpio_write(8'h01, 8'h5B, 4);
      chk("long_word", {48'd0, m_data[31:16]}, 64'h5A5B);
      chk("long_word_vld", {63'd0, m_valid[1]}, 64'd1);

      // ready rises in the same cycle the next word completes
      gpio_write(8'h02, 8'h22, 4);
      gpio_write(8'h02, 8'h22, 4);
      chk("b2b_first", {48'd0, m_data[47:32]}, 64'h2222);
      gpio_write(8'h02, 8'h33, 4);
      @(negedge clk);
      gpio_in = {1'b1, 15'd0, 8'h02, 8'h33};
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_hold", {47'd0, m_valid[2], m_data[47:32]}, 64'h1_2222);
      @(negedge clk);
      m_rdy[2] = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_second", {47'd0, m_valid[2], m_data[47:32]}, 64'h1_3333);
      chk("b2b_ovf", {63'd0, ovf[2]}, 64'd0);
      @(posedge clk);
      #1;
      chk("b2b_taken", {63'd0, m_valid[2]}, 64'd0);
      @(negedge clk);
      gpio_in[31] = 1'b0;
      repeat (6) @(negedge clk);

      // reset mid-word discards the partial beat
      m_rdy = 4'b0001;
      gpio_write(8'h00, 8'h55, 4);
      chk("mid_pend", {63'd0, beat_pend[0]}, 64'd1);
      do_reset();
      chk("mid_rst_data", m_data, 64'h0);
      chk("mid_rst_flags", {52'd0, m_valid, ovf, beat_pend}, 64'h0);
      gpio_write(8'h00, 8'h66, 4);
      gpio_write(8'h00, 8'h77, 4);
      chk("mid_word", m_data, 64'h6677);
      gpio_write(8'h05, 8'h01, 4);
      gpio_write(8'hFF, 8'hFF, 4);
      chk("illegal_data", m_data, 64'h6677);
      chk("illegal_flags", {52'd0, m_valid, ovf, beat_pend}, 64'h0);

      // random phase
      m_rdy = '0;
      do_reset();
      model_clear();
      for (int it = 0; it < 80; it++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) a = 8'(sel % 4);
         else if (sel < 8) a = 8'd4;
         else if (sel == 8) a = 8'd5;
         else a = 8'($urandom_range(6, 255));
         d = 8'($urandom);
         r = 4'($urandom);
         m_rdy = r;
         model_write(a, d, r);
         gpio_write(a, d, $urandom_range(4, 8));
         model_cmp(it);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
